// File: rtl/fuzz_stim_driver.sv
// LFSR-driven stimulus generator and MISR response compactor for the fuzz harness.
// Each step drives clkin_data/in_data for one cycle and samples out_data on the next.
module fuzz_stim_driver #(
  parameter int unsigned NUM_STEPS     = 256,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  seed,
  output logic         busy,
  output logic         done,
  output logic [31:0]  signature,
  output logic [15:0]  step_count,
  output logic [191:0] clkin_data,
  output logic [95:0]  in_data,
  input  logic [95:0]  out_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] IN_MASK   = 32'hA5A5A5A5;

  logic [2:0]  state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  settle_q, settle_d;
  logic [5:0]  lanes_q, lanes_d;
  logic [95:0] in_data_q, in_data_d;
  logic [31:0] lfsr_next;

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    sig_d     = sig_q;
    step_d    = step_q;
    settle_d  = settle_q;
    lanes_d   = lanes_q;
    in_data_d = in_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
          sig_d   = 32'h0;
          step_d  = 16'h0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        lfsr_d    = lfsr_next;
        in_data_d = {~lfsr_next, lfsr_next ^ IN_MASK, lfsr_next};
        // A lane toggles (produces an edge) wherever the new LFSR bit is set.
        lanes_d   = lanes_q ^ lfsr_next[5:0];
        state_d   = S_SAMPLE;
      end
      S_SAMPLE: begin
        sig_d  = {sig_q[30:0], sig_q[31]} ^ out_data[95:64] ^ out_data[63:32] ^ out_data[31:0];
        step_d = step_q + 16'd1;
        if (step_d == 16'(NUM_STEPS)) begin
          settle_d = 8'(SETTLE_CYCLES);
          state_d  = S_SETTLE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (settle_q == 8'd1) state_d = S_DONE;
      end
      S_DONE: begin
        lanes_d = '1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 32'h1;
      sig_q     <= 32'h0;
      step_q    <= 16'h0;
      settle_q  <= 8'h0;
      lanes_q   <= '1;
      in_data_q <= 96'h0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      sig_q     <= sig_d;
      step_q    <= step_d;
      settle_q  <= settle_d;
      lanes_q   <= lanes_d;
      in_data_q <= in_data_d;
    end
  end

  always_comb begin
    clkin_data = '0;
    for (int k = 0; k < 6; k++) clkin_data[32*k] = lanes_q[k];
  end

  assign busy       = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_SETTLE);
  assign done       = (state_q == S_DONE);
  assign signature  = sig_q;
  assign step_count = step_q;
  assign in_data    = in_data_q;

endmodule

// File: tb/tb_fuzz_stim_driver.sv
// Directed bench for fuzz_stim_driver: expected run results are queued at start,
// a monitor pops and compares them on each done pulse.
module tb_fuzz_stim_driver;

  localparam int unsigned N = 4;
  localparam int unsigned S = 2;
  localparam logic [191:0] LANES_ALL   = {6{32'h00000001}};
  localparam logic [191:0] LANES_FIRST = {{4{32'h00000001}}, 64'h0};
  localparam logic [95:0]  IN_FIRST    = {32'h7FDFFFFC, 32'h2585A5A6, 32'h80200003};
  localparam logic [31:0]  SIG_LOOP1   = 32'h71DC0016;

  typedef struct {
    logic [31:0] sig;
    logic [15:0] steps;
    int          cycles;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  seed = 32'h0;
  logic         busy, done;
  logic [31:0]  signature;
  logic [15:0]  step_count;
  logic [191:0] clkin_data;
  logic [95:0]  in_data, out_data;
  logic         loopback = 1'b0;
  logic [95:0]  out_pat = 96'h0;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cyc = 0;
  exp_t sb[$];

  // Loopback feeds the driven LFSR word straight back as the response.
  assign out_data = loopback ? {64'h0, in_data[31:0]} : out_pat;

  fuzz_stim_driver #(.NUM_STEPS(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .signature(signature), .step_count(step_count),
    .clkin_data(clkin_data), .in_data(in_data), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each done pulse against the oldest queued expectation.
  initial forever begin
    @(negedge clk);
    if (rst) busy_cyc = 0;
    else begin
      if (busy) busy_cyc++;
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done with empty scoreboard");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("signature", 192'(signature), 192'(e.sig));
          check("step_count", 192'(step_count), 192'(e.steps));
          check("busy_cycles", 192'(busy_cyc), 192'(e.cycles));
        end
        busy_cyc = 0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] s);
    exp_t e;
    e.sig = s;
    e.steps = 16'(N);
    e.cycles = 2 * N + S;
    sb.push_back(e);
  endtask

  task automatic start_run(input logic [31:0] s);
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 192'(busy), 192'(1'b1));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
    end
    @(negedge clk);
    check({name, "_lanes_idle"}, clkin_data, LANES_ALL);
    check({name, "_busy_idle"}, 192'(busy), 192'(1'b0));
  endtask

  task automatic first_drive_checks(input string name);
    @(negedge clk);
    check({name, "_in_data"}, 192'(in_data), 192'(IN_FIRST));
    check({name, "_lanes"}, clkin_data, LANES_FIRST);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 192'(busy), 192'(1'b0));
    check("rst_done", 192'(done), 192'(1'b0));
    check("rst_sig", 192'(signature), 192'(32'h0));
    check("rst_lanes", clkin_data, LANES_ALL);
    check("rst_in_data", 192'(in_data), 192'(96'h0));

    // start coincident with reset is dropped
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    seed = 32'h1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 192'(busy), 192'(1'b0));

    // seed 1 with loopback response
    loopback = 1'b1;
    push_exp(SIG_LOOP1);
    start_run(32'h1);
    first_drive_checks("seed1");
    wait_done("seed1");

    // zero seed behaves as seed 1
    push_exp(SIG_LOOP1);
    start_run(32'h0);
    first_drive_checks("seed0");
    wait_done("seed0");

    // constant responses
    loopback = 1'b0;
    out_pat = 96'h1;
    push_exp(32'h0000000F);
    start_run(32'h12345678);
    wait_done("const1");

    out_pat = {32'h000000F0, 32'h0000000F, 32'h00000000};
    push_exp(32'h00000505);
    start_run(32'hCAFEF00D);
    wait_done("constFF");

    out_pat = 96'h0;
    push_exp(32'h0);
    start_run(32'h0BADBEEF);
    wait_done("zero");

    // start while busy is ignored
    loopback = 1'b1;
    push_exp(SIG_LOOP1);
    start_run(32'h1);
    repeat (3) @(negedge clk);
    seed = 32'hDEADBEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed = 32'h0;
    wait_done("busy_start");

    // reset in step 2 of 4 aborts the run
    start_run(32'h1);
    begin
      int n = 0;
      while (step_count != 16'd1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("midrst_reach_step", 192'(step_count), 192'(16'd1));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 192'(busy), 192'(1'b0));
    check("midrst_sig", 192'(signature), 192'(32'h0));
    check("midrst_steps", 192'(step_count), 192'(16'h0));
    check("midrst_in_data", 192'(in_data), 192'(96'h0));
    check("midrst_lanes", clkin_data, LANES_ALL);

    push_exp(SIG_LOOP1);
    start_run(32'h1);
    first_drive_checks("rerun");
    wait_done("rerun");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 192'(sb.size()), 192'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_stim_driver.md
# fuzz_stim_driver

Sequential stimulus generator and response compactor for the fuzz-harness top. It drives the DUT's `clkin_data` (six edge lanes) and `in_data` from a seeded 32-bit LFSR, samples the DUT's `out_data` once per step, and folds each sample into a 32-bit signature. A run is started by a `start` pulse and finishes with a one-cycle `done` pulse. It is the producing end of the `clkin_data`/`in_data`/`out_data` interface.

## Interface
- `NUM_STEPS`, 256: drive/sample steps per run; legal range 1..65535.
- `SETTLE_CYCLES`, 2: idle cycles after the last sample before `done`; legal range 1..255.
- `clk`  in  1  block clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `seed`  in  32  LFSR seed, latched with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done` is asserted.
- `done`  out  1  one-cycle pulse at the end of a run.
- `signature`  out  32  MISR result; valid from `done` until the next accepted `start`.
- `step_count`  out  16  completed SAMPLE steps in the current or last run.
- `clkin_data`  out  192  edge lanes to the DUT.
- `in_data`  out  96  data to the DUT.
- `out_data`  in  96  DUT response.

## Operation
- Lane k (k = 0..5) is `clkin_data[32k]`. Every other bit of `clkin_data` is constant 0.
- LFSR is Galois, right-shift:
  - `next = (l >> 1) ^ (l[0] ? 32'h80200003 : 0)`.
  - A seed of 0 is replaced by `32'h00000001`.
- `in_data = {~l, l ^ 32'hA5A5A5A5, l}`, using the post-advance LFSR value.
- MISR update: `sig <= {sig[30:0], sig[31]} ^ out_data[95:64] ^ out_data[63:32] ^ out_data[31:0]`.
- State machine:
  - **IDLE**
    - With `start`=1: latch seed (zero replaced), clear `sig` and `step_count`, go to DRIVE.
    - Otherwise stay in IDLE.
  - **DRIVE**
    - Advance the LFSR.
    - Update `in_data`.
    - Toggle lane k for every k where the new `l[k]` = 1.
    - Go to SAMPLE.
  - **SAMPLE**
    - Fold `out_data` into `sig`.
    - Increment `step_count`.
    - If the new `step_count` equals `NUM_STEPS`, load the settle counter with `SETTLE_CYCLES` and go to SETTLE. Otherwise go to DRIVE.
  - **SETTLE**
    - `in_data` and the lanes hold their values.
    - Decrement the counter. When it reaches 0, go to DONE.
  - **DONE**
    - `done`=1 and `busy`=0 for this single cycle.
    - Return all lanes to 1 and go to IDLE.
- `start` is ignored outside IDLE. `seed` is ignored except when `start` is accepted.
- `signature` and `step_count` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `signature`=0, `step_count`=0.
  - `in_data`=0.
  - `clkin_data` has bits 0, 32, 64, 96, 128 and 160 set to 1; all other bits are 0.
  - LFSR = 1.
- Let edge E0 be the edge that accepts `start`.
  - `busy`=1 after E0.
  - Step n (1-based) drives at E(2n−1) and samples at E(2n). The DUT therefore gets one full cycle between a drive and its sample.
  - SETTLE is entered at E(2N). DONE is entered at E(2N+S), so `done` is high during the cycle after E(2N+S).
  - IDLE is re-entered at E(2N+S+1). A `start` is accepted at that edge at the earliest.
  - Total run length: `busy` is high for 2N+S cycles.
- `rst` mid-run has priority over everything. It restores every reset value at that edge, and the partial signature is discarded.
- `start` coincident with `rst`: reset wins and `start` is dropped.
- `step_count` never wraps, because `NUM_STEPS` ≤ 65535.

## Test plan
- **Reset values:** hold `rst` 2 cycles → `busy`=0, `done`=0, `signature`=0, `clkin_data`=bits 0/32/64/96/128/160 set, `in_data`=0.
- **First step, seed 1:** `seed`=1 + `start` → after the first DRIVE:
  - `in_data` = `{32'h7FDFFFFC, 32'h2585A5A6, 32'h80200003}`.
  - Lanes 0 and 1 = 0; lanes 2–5 = 1.
- **Zero seed:** `seed`=0 gives stimulus identical to `seed`=1, cycle for cycle.
- **MISR, non-trivial:** `NUM_STEPS`=4, `SETTLE_CYCLES`=2, `out_data` held at 96'h1 → `done` pulses 10 cycles after E0 with `signature`=`32'h0000000F`, `step_count`=4, and all lanes return to 1.
- **MISR, zero input:** `out_data` tied to 0 for any run → `signature`=0.
- **Start while busy:** pulse `start` mid-run with a different seed → no effect on the stimulus, the signature or the timing of `done`.
- **Reset mid-run:** assert `rst` at step 2 of 4 → IDLE at the next edge with all reset values. A following run with the same seed reproduces the result of a clean run exactly.
